regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
Shares one register-file read port among N_REQ requesters, such as decode operand fetch, the multdiv unit and the debug unit. Each requester issues a register index over a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order, drives RD_REG into the read port and samples DATA_READ. It returns the data tagged with the requester ID through a 2-stage, backpressure-aware pipeline, forwarding a same-cycle regfile write when required.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must equal ceil(log2(N_REQ))
ZERO_R0, 1, when 1, reads of register 0 return 32'h0 regardless of DATA_READ
BYPASS, 1, when 1, forward WR_DATA when a write hits the register being sampled

Ports:
CLK  input  1  clock, rising-edge
RESET_N  input  1  asynchronous, active-low reset
REQ_VALID  input  N_REQ  per-requester request valid
REQ_REG  input  5*N_REQ  per-requester register index; requester i uses bits [5i+4:5i]
REQ_READY  output  N_REQ  per-requester grant; one-hot or zero
RD_REG  output  5  register index to the read port
DATA_READ  input  32  combinational data from the read port for RD_REG
WR_EN  input  1  regfile write enable for this cycle
WR_REG  input  5  regfile write index
WR_DATA  input  32  regfile write data
RSP_VALID  output  1  response valid
RSP_ID  output  ID_W  requester that owns the response
RSP_DATA  output  32  register data
RSP_READY  input  1  response consumer accept
BUSY  output  1  high when either pipeline stage holds a request

Behaviour:
- Pipeline stages:
  - S1 (address): holds valid, id and reg.
  - S2 (response): holds valid, id and data.
- RD_REG = S1.reg while S1 is valid, else 5'd0.
- Arbitration is combinational:
  - Search REQ_VALID starting at index RR_PTR and wrapping mod N_REQ.
  - The first set bit i wins.
  - REQ_READY[i] = 1 only if adv1 holds. All other bits are 0.
- Stall conditions:
  - s2_free = !S2.valid | RSP_READY.
  - adv1 = !S1.valid | s2_free.
- Handshake: a transfer occurs when REQ_VALID[i] & REQ_READY[i]. The requester must hold REQ_VALID and REQ_REG stable until granted.
- On a transfer at edge t: S1 <= {1, i, REQ_REG[i]}, RR_PTR <= (i+1) mod N_REQ. RR_PTR is unchanged when there is no grant.
- When S1 is valid and s2_free, S1 moves into S2 at the next edge with data chosen as follows:
  - ZERO_R0 && S1.reg == 0: data = 32'h0.
  - Else if BYPASS && WR_EN && WR_REG == S1.reg && WR_REG != 0: data = WR_DATA.
  - Else: data = DATA_READ.
- If S1 is valid, S1 does not advance, and no new grant occurs, S1 holds and RD_REG holds.
- If S1 advances with no new grant, S1.valid <= 0.
- S2 clears when RSP_READY is high and nothing advances into it.
- Outputs: RSP_VALID = S2.valid, RSP_ID = S2.id, RSP_DATA = S2.data. All are registered and held stable while RSP_VALID & !RSP_READY.
- BUSY = S1.valid | S2.valid.
- Latency: grant at edge t, RD_REG valid after edge t, RSP_VALID after edge t+1. With RSP_READY held high, throughput is 1 per cycle.
- Reset (RESET_N low, asynchronous): S1.valid = S2.valid = 0, RR_PTR = 0, RD_REG = 0, RSP_VALID = 0, RSP_ID = 0, RSP_DATA = 0, BUSY = 0. REQ_READY is forced to 0 while in reset. A reset mid-operation drops in-flight requests and produces no response.
- Simultaneous events:
  - A grant and an S1->S2 move on the same edge are both legal.
  - With a single requester continuously valid, that requester is granted every cycle.
  - REQ_REG values are accepted without checking, since all indexes 0..31 are legal.

Test Plan:
- Reset, then requester 2 only, REQ_REG = 7, regfile r7 = 32'hDEAD_BEEF -> REQ_READY = 4'b0100 at t, RD_REG = 7 at t+1, RSP_VALID/ID/DATA = 1/2/DEAD_BEEF at t+2.
- All 4 requesters valid continuously, RSP_READY = 1 -> grants cycle 0,1,2,3,0,...; responses in the same order, one per cycle.
- RSP_READY low for 3 cycles with two requests in flight -> RSP_DATA and RD_REG held, REQ_READY = 0; on release, both responses arrive in order with no loss or duplication.
- Read r5 while WR_EN = 1, WR_REG = 5, WR_DATA = 32'h1234_5678 in the S1 cycle, DATA_READ = old value -> RSP_DATA = 32'h1234_5678. Repeat with WR_REG = 0 and read r0 -> RSP_DATA = 0.
- Assert RESET_N low while S1 and S2 are both valid -> outputs clear immediately, no response after release, next grant goes to requester 0 first.
- Requester 1 holds valid with requester 0 and requester 3 also valid, RR_PTR = 1 -> order 1, 3, 0; verify no starvation over 100 cycles of random REQ_VALID.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Round-robin arbiter that shares one register-file read port among N_REQ
//   requesters. A grant loads the address stage (S1), which drives RD_REG. On
//   the next edge the sampled data moves into the response stage (S2) with
//   the owning requester ID. A write to the same register in that cycle is
//   forwarded, and r0 can be forced to read as zero.
//
// Ports
//   CLK, RESET_N          clock, asynchronous active-low reset
//   REQ_VALID/REQ_REG     per-requester request and 5-bit register index
//   REQ_READY             one-hot (or zero) grant, combinational
//   RD_REG / DATA_READ    read-port address out and combinational data in
//   WR_EN/WR_REG/WR_DATA  same-cycle regfile write, used for forwarding
//   RSP_VALID/ID/DATA     registered response, held while stalled
//   RSP_READY             response consumer accept
//   BUSY                  either pipeline stage occupied
`timescale 1ns/1ps
module regfile_read_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [N_REQ-1:0]      REQ_VALID,
  input  logic [5*N_REQ-1:0]    REQ_REG,
  output logic [N_REQ-1:0]      REQ_READY,
  output logic [4:0]            RD_REG,
  input  logic [31:0]           DATA_READ,
  input  logic                  WR_EN,
  input  logic [4:0]            WR_REG,
  input  logic [31:0]           WR_DATA,
  output logic                  RSP_VALID,
  output logic [ID_W-1:0]       RSP_ID,
  output logic [31:0]           RSP_DATA,
  input  logic                  RSP_READY,
  output logic                  BUSY
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [REG_W-1:0]  rg;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } s2_t;

  s1_t              s1_q;
  s2_t              s2_q;
  logic [ID_W-1:0]  rr_ptr_q;

  logic             s2_free;
  logic             adv1;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [REG_W-1:0] grant_reg;
  logic             grant;
  logic [ID_W-1:0]  rr_next;
  logic [DATA_W-1:0] s1_data;

  assign s2_free = !s2_q.valid || RSP_READY;
  assign adv1    = !s1_q.valid || s2_free;

  // Round-robin search starting at rr_ptr_q, wrapping mod N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_reg   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && REQ_VALID[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
        grant_reg   = REQ_REG[REG_W*idx +: REG_W];
      end
    end
  end

  assign grant     = grant_found && adv1;
  assign REQ_READY = (grant && RESET_N) ? (N_REQ'(1) << grant_id) : '0;
  assign rr_next   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // Read data for the register held in S1: r0 zeroing, then write forwarding.
  always_comb begin
    s1_data = DATA_READ;
    if (ZERO_R0 && (s1_q.rg == '0)) begin
      s1_data = '0;
    end else if (BYPASS && WR_EN && (WR_REG == s1_q.rg) && (WR_REG != '0)) begin
      s1_data = WR_DATA;
    end
  end

  // Address stage and round-robin pointer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (adv1) begin
        s1_q.valid <= grant;
        if (grant) begin
          s1_q.id  <= grant_id;
          s1_q.rg  <= grant_reg;
        end
      end
      if (grant) begin
        rr_ptr_q <= rr_next;
      end
    end
  end

  // Response stage; payload only changes when something moves in.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_q <= '0;
    end else if (s2_free) begin
      s2_q.valid <= s1_q.valid;
      if (s1_q.valid) begin
        s2_q.id   <= s1_q.id;
        s2_q.data <= s1_data;
      end
    end
  end

  assign RD_REG    = s1_q.valid ? s1_q.rg : '0;
  assign RSP_VALID = s2_q.valid;
  assign RSP_ID    = s2_q.id;
  assign RSP_DATA  = s2_q.data;
  assign BUSY      = s1_q.valid || s2_q.valid;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_read_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  REQ_VALID;
  logic [19:0] req_reg;
  logic [3:0]  REQ_READY;
  logic [4:0]  RD_REG;
  logic [31:0] DATA_READ;
  logic        WR_EN;
  logic [4:0]  WR_REG;
  logic [31:0] WR_DATA;
  logic        RSP_VALID;
  logic [1:0]  RSP_ID;
  logic [31:0] RSP_DATA;
  logic        RSP_READY;
  logic        BUSY;

  logic [31:0] rf [32];
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign DATA_READ = rf[RD_REG];

  regfile_read_arbiter #(.N_REQ(4), .ID_W(2), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_REG(req_reg),
    .REQ_READY(REQ_READY), .RD_REG(RD_REG), .DATA_READ(DATA_READ),
    .WR_EN(WR_EN), .WR_REG(WR_REG), .WR_DATA(WR_DATA),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
    .RSP_READY(RSP_READY), .BUSY(BUSY)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; REQ_VALID = 4'b1111; req_reg = '0; RSP_READY = 1'b1;
    WR_EN = 1'b0; WR_REG = '0; WR_DATA = '0;
    tick; tick;
    checks++; if (REQ_READY !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", REQ_READY); end
    checks++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL reset_valid_busy: got %b/%b expected 0/0", RSP_VALID, BUSY); end
    checks++; if (RD_REG !== 5'd0 || RSP_ID !== 2'd0 || RSP_DATA !== 32'd0) begin failures++; $display("FAIL reset_outputs: got rd=%0d id=%0d data=%h expected 0/0/0", RD_REG, RSP_ID, RSP_DATA); end
    REQ_VALID = 4'b0000;
    RESET_N = 1'b1;
    tick;
  endtask

  task automatic test_single;
    REQ_VALID = 4'b0100; req_reg[14:10] = 5'd7;
    #1;
    checks++; if (REQ_READY !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b expected 0100", REQ_READY); end
    tick;
    REQ_VALID = 4'b0000;
    checks++; if (RD_REG !== 5'd7 || RSP_VALID !== 1'b0) begin failures++; $display("FAIL single_rdreg: got rd=%0d rv=%b expected 7/0", RD_REG, RSP_VALID); end
    tick;
    checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd2 || RSP_DATA !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL single_rsp: got %b/%0d/%h expected 1/2/deadbeef", RSP_VALID, RSP_ID, RSP_DATA); end
    tick;
    checks++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL single_drain: got %b/%b expected 0/0", RSP_VALID, BUSY); end
  endtask

  task automatic test_round_robin;
    RESET_N = 1'b0; tick; RESET_N = 1'b1; tick;
    for (int i = 0; i < 4; i++) req_reg[5*i +: 5] = 5'(8 + i);
    REQ_VALID = 4'b1111;
    for (int c = 0; c <= 10; c++) begin
      logic [3:0] exp_rdy;
      if (c >= 8) REQ_VALID = 4'b0000;
      #1;
      exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checks++; if (REQ_READY !== exp_rdy) begin failures++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, REQ_READY, exp_rdy); end
      if (c >= 2 && c < 10) begin
        checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'((c - 2) % 4) || RSP_DATA !== (32'hA000_0000 | 32'(8 + (c - 2) % 4))) begin
          failures++; $display("FAIL rr_rsp c=%0d: got %b/%0d/%h expected 1/%0d", c, RSP_VALID, RSP_ID, RSP_DATA, (c - 2) % 4); end
      end else begin
        checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL rr_idle c=%0d: got %b expected 0", c, RSP_VALID); end
      end
      tick;
    end
  endtask

  task automatic test_stall;
    req_reg[4:0] = 5'd1; req_reg[9:5] = 5'd2; req_reg[14:10] = 5'd3;
    REQ_VALID = 4'b0011;
    #1;
    checks++; if (REQ_READY !== 4'b0001) begin failures++; $display("FAIL stall_g0: got %b expected 0001", REQ_READY); end
    tick;
    REQ_VALID = 4'b0010;
    #1;
    checks++; if (REQ_READY !== 4'b0010) begin failures++; $display("FAIL stall_g1: got %b expected 0010", REQ_READY); end
    tick;
    REQ_VALID = 4'b0100; RSP_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (REQ_READY !== 4'b0000 || RD_REG !== 5'd2) begin failures++; $display("FAIL stall_hold c=%0d: got rdy=%b rd=%0d expected 0000/2", c, REQ_READY, RD_REG); end
      checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd0 || RSP_DATA !== 32'hA000_0001) begin
        failures++; $display("FAIL stall_rsp c=%0d: got %b/%0d/%h expected 1/0/a0000001", c, RSP_VALID, RSP_ID, RSP_DATA); end
      if (c < 2) tick; else begin @(posedge CLK); #1; end
    end
    RSP_READY = 1'b1;
    #1;
    checks++; if (REQ_READY !== 4'b0100) begin failures++; $display("FAIL stall_release_ready: got %b expected 0100", REQ_READY); end
    tick;
    REQ_VALID = 4'b0000;
    checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd1 || RSP_DATA !== 32'hA000_0002) begin
      failures++; $display("FAIL stall_rsp1: got %b/%0d/%h expected 1/1/a0000002", RSP_VALID, RSP_ID, RSP_DATA); end
    tick;
    checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd2 || RSP_DATA !== 32'hA000_0003) begin
      failures++; $display("FAIL stall_rsp2: got %b/%0d/%h expected 1/2/a0000003", RSP_VALID, RSP_ID, RSP_DATA); end
    tick;
    checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL stall_nodup: got %b expected 0", RSP_VALID); end
  endtask

  task automatic test_bypass;
    logic [4:0]  rd_v [3];
    logic [4:0]  wr_v [3];
    logic [31:0] wd_v [3];
    logic [31:0] ex_v [3];
    rd_v[0] = 5'd5; wr_v[0] = 5'd5; wd_v[0] = 32'h1234_5678; ex_v[0] = 32'h1234_5678;
    rd_v[1] = 5'd0; wr_v[1] = 5'd0; wd_v[1] = 32'hCAFE_F00D; ex_v[1] = 32'h0000_0000;
    rd_v[2] = 5'd5; wr_v[2] = 5'd6; wd_v[2] = 32'h9999_9999; ex_v[2] = 32'h5555_5555;
    for (int v = 0; v < 3; v++) begin
      REQ_VALID = 4'b0001; req_reg[4:0] = rd_v[v];
      #1;
      checks++; if (REQ_READY !== 4'b0001) begin failures++; $display("FAIL bypass_ready v=%0d: got %b expected 0001", v, REQ_READY); end
      tick;
      REQ_VALID = 4'b0000; WR_EN = 1'b1; WR_REG = wr_v[v]; WR_DATA = wd_v[v];
      tick;
      WR_EN = 1'b0;
      checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== ex_v[v]) begin
        failures++; $display("FAIL bypass_data v=%0d: got %b/%h expected 1/%h", v, RSP_VALID, RSP_DATA, ex_v[v]); end
      tick;
    end
  endtask

  task automatic test_mid_reset;
    req_reg[14:10] = 5'd20; req_reg[19:15] = 5'd21;
    REQ_VALID = 4'b1100;
    #1;
    checks++; if (REQ_READY !== 4'b0100) begin failures++; $display("FAIL mrst_g2: got %b expected 0100", REQ_READY); end
    tick;
    REQ_VALID = 4'b1000;
    tick;
    REQ_VALID = 4'b1100;
    checks++; if (BUSY !== 1'b1 || RSP_VALID !== 1'b1 || RD_REG !== 5'd21) begin failures++; $display("FAIL mrst_full: got busy=%b rv=%b rd=%0d expected 1/1/21", BUSY, RSP_VALID, RD_REG); end
    RESET_N = 1'b0;
    #1;
    checks++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0 || RD_REG !== 5'd0 || RSP_ID !== 2'd0 || RSP_DATA !== 32'd0 || REQ_READY !== 4'b0000) begin
      failures++; $display("FAIL mrst_clear: got rv=%b busy=%b rd=%0d id=%0d data=%h rdy=%b expected all 0", RSP_VALID, BUSY, RD_REG, RSP_ID, RSP_DATA, REQ_READY); end
    tick; tick;
    REQ_VALID = 4'b0000; RESET_N = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL mrst_norsp c=%0d: got %b/%b expected 0/0", c, RSP_VALID, BUSY); end
    end
    REQ_VALID = 4'b1001; req_reg[4:0] = 5'd4;
    #1;
    checks++; if (REQ_READY !== 4'b0001) begin failures++; $display("FAIL mrst_first: got %b expected 0001", REQ_READY); end
    tick;
    REQ_VALID = 4'b0000;
    tick; tick; tick;
  endtask

  task automatic test_starvation;
    logic [3:0] pend;
    logic [3:0] exp_rdy;
    int ptr, g, max_wait;
    int wcnt [4];
    int gcnt [4];
    logic e1_v, e2_v;
    int e1_id, e2_id;
    req_reg[4:0] = 5'd10; req_reg[9:5] = 5'd11; req_reg[14:10] = 5'd12; req_reg[19:15] = 5'd13;
    REQ_VALID = 4'b1011;
    #1;
    checks++; if (REQ_READY !== 4'b0010) begin failures++; $display("FAIL order_1: got %b expected 0010", REQ_READY); end
    tick;
    REQ_VALID = 4'b1001;
    #1;
    checks++; if (REQ_READY !== 4'b1000) begin failures++; $display("FAIL order_3: got %b expected 1000", REQ_READY); end
    tick;
    REQ_VALID = 4'b0001;
    #1;
    checks++; if (REQ_READY !== 4'b0001 || RSP_ID !== 2'd1) begin failures++; $display("FAIL order_0: got rdy=%b id=%0d expected 0001/1", REQ_READY, RSP_ID); end
    tick;
    REQ_VALID = 4'b0000;
    checks++; if (RSP_ID !== 2'd3) begin failures++; $display("FAIL order_rsp3: got %0d expected 3", RSP_ID); end
    tick;
    checks++; if (RSP_ID !== 2'd0) begin failures++; $display("FAIL order_rsp0: got %0d expected 0", RSP_ID); end
    tick; tick;

    ptr = 1; pend = 4'b0000; max_wait = 0;
    e1_v = 1'b0; e2_v = 1'b0; e1_id = 0; e2_id = 0;
    for (int j = 0; j < 4; j++) begin wcnt[j] = 0; gcnt[j] = 0; end
    for (int c = 0; c < 100; c++) begin
      REQ_VALID = pend;
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) if (g < 0 && pend[(ptr + k) % 4]) g = (ptr + k) % 4;
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      checks++; if (REQ_READY !== exp_rdy) begin failures++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, REQ_READY, exp_rdy); end
      checks++; if (RSP_VALID !== e2_v || (e2_v && (RSP_ID !== 2'(e2_id) || RSP_DATA !== (32'hA000_0000 | 32'(10 + e2_id))))) begin
        failures++; $display("FAIL rand_rsp c=%0d: got %b/%0d/%h expected %b/%0d", c, RSP_VALID, RSP_ID, RSP_DATA, e2_v, e2_id); end
      tick;
      e2_v = e1_v; e2_id = e1_id;
      e1_v = (g >= 0); e1_id = (g >= 0) ? g : 0;
      if (g >= 0) begin pend[g] = 1'b0; ptr = (g + 1) % 4; gcnt[g]++; end
      for (int j = 0; j < 4; j++) begin
        if (pend[j]) begin
          wcnt[j]++;
          if (wcnt[j] > max_wait) max_wait = wcnt[j];
        end else begin
          wcnt[j] = 0;
          pend[j] = 1'($urandom_range(0, 1));
        end
      end
    end
    REQ_VALID = 4'b0000;
    checks++; if (max_wait > 3) begin failures++; $display("FAIL starve_wait: got %0d expected <= 3", max_wait); end
    checks++; if (gcnt[0] == 0 || gcnt[1] == 0 || gcnt[2] == 0 || gcnt[3] == 0) begin
      failures++; $display("FAIL starve_grants: got %0d/%0d/%0d/%0d expected all nonzero", gcnt[0], gcnt[1], gcnt[2], gcnt[3]); end
    tick; tick; tick;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'hA000_0000 | 32'(r);
    rf[0] = 32'hFFFF_FFFF;
    rf[5] = 32'h5555_5555;
    rf[7] = 32'hDEAD_BEEF;
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_bypass;
    test_mid_reset;
    test_starvation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
